// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU at the EX stage.
// One quotient bit per CALC cycle, a FIX cycle applies signs, DONE holds the result.
module div_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  div_start,
    output logic                  div_ready,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] div_dividend,
    input  logic [DATA_WIDTH-1:0] div_divisor,
    input  logic                  div_kill,
    output logic                  div_res_valid,
    input  logic                  div_res_ready,
    output logic [DATA_WIDTH-1:0] div_result,
    output logic                  div_busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH:0]     rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    is_rem_q, is_rem_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;

    logic                    accept;
    logic                    op_signed, op_rem;
    logic                    dvd_neg, dvs_neg;
    logic [DATA_WIDTH-1:0]   dvd_mag, dvs_mag;
    logic                    div_zero, overflow, special;
    logic [DATA_WIDTH-1:0]   special_res;
    logic [DATA_WIDTH+1:0]   shifted;
    logic [DATA_WIDTH:0]     diff;
    logic                    ge;

    // Request decode: magnitudes and early-out results are formed from the live inputs.
    assign accept      = div_start && (state_q == S_IDLE) && !div_kill;
    assign op_signed   = ~div_op[0];
    assign op_rem      = div_op[1];
    assign dvd_neg     = op_signed & div_dividend[DATA_WIDTH-1];
    assign dvs_neg     = op_signed & div_divisor[DATA_WIDTH-1];
    assign dvd_mag     = dvd_neg ? -div_dividend : div_dividend;
    assign dvs_mag     = dvs_neg ? -div_divisor : div_divisor;
    assign div_zero    = (div_divisor == '0);
    assign overflow    = op_signed && (div_dividend == MIN_NEG) && (div_divisor == '1);
    assign special     = div_zero | overflow;
    assign special_res = div_zero ? (op_rem ? div_dividend : '1)
                                  : (op_rem ? '0 : MIN_NEG);

    // Restoring step; the extra remainder bit keeps the compare from wrapping.
    assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    assign ge      = shifted >= {2'b00, dvs_q};
    assign diff    = shifted[DATA_WIDTH:0] - {1'b0, dvs_q};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (div_res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (div_kill) state_d = S_IDLE;
    end

    always_comb begin
        div_ready     = (state_q == S_IDLE);
        div_busy      = (state_q != S_IDLE);
        div_res_valid = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    is_rem_d  = op_rem;
                    neg_quo_d = dvd_neg ^ dvs_neg;
                    neg_rem_d = dvd_neg;
                    if (special) result_d = special_res;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                rem_d = ge ? diff : shifted[DATA_WIDTH:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], ge};
            end
            S_FIX: begin
                // A flush in FIX must leave the previously presented result untouched.
                if (!div_kill) begin
                    if (is_rem_q)
                        result_d = neg_rem_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
                    else
                        result_d = neg_quo_q ? -quo_q : quo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign div_result = result_q;

endmodule
